// File: rtl/prmcu_uart_pkg.sv
// prmcu_uart_pkg: shared receiver state type and configuration limits
package prmcu_uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
  localparam int MIN_DATA_BITS = 5;
  localparam int MAX_DATA_BITS = 9;
  localparam int MIN_DIVIDER = 4;
endpackage

// File: rtl/prmcu_sync.sv
// prmcu_sync: SYNC_STAGES-deep flop chain bringing d into the clk domain
// ports: clk, rst (sync, active-low, presets chain to 1), d (async in), q (synchronized out)
module prmcu_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] r_ff;
  always_ff @(posedge clk) r_ff <= !rst ? '1 : SYNC_STAGES'({r_ff, d});
  assign q = r_ff[SYNC_STAGES-1];
endmodule

// File: rtl/prmcu_uart_rx.sv
// prmcu_uart_rx: configurable UART receiver with one-entry output register
// ports: clk, rst (sync, active-low), rx_en, frame config (n_parity_bits_i, n_stop_bits_i,
//   n_data_bits_i, clk_divider_i), rx_i serial line, out_dat_o/out_vld_o/out_rdy_i handshake,
//   parity_err_o/frame_err_o (per word), overrun_err_o (pulse), busy_o
module prmcu_uart_rx
  import prmcu_uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_en,
  input  logic       n_parity_bits_i,
  input  logic [1:0] n_stop_bits_i,
  input  logic [3:0] n_data_bits_i,
  input  logic [7:0] clk_divider_i,
  input  logic       rx_i,
  output logic [8:0] out_dat_o,
  output logic       out_vld_o,
  input  logic       out_rdy_i,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       overrun_err_o,
  output logic       busy_o
);
  rx_state_t r_state, w_next;
  logic w_rx, r_rx_prev;
  logic [3:0] r_nbits, w_nbits;
  logic [7:0] r_div, w_div, r_cnt;
  logic r_par, r_stop2;
  logic [3:0] r_idx;
  logic [8:0] r_shift, r_dat;
  logic r_xor, r_perr, r_ferr;
  logic r_vld, r_pe, r_fe, r_ovr;
  logic w_start, w_tick, w_last_data, w_last_stop, w_done;

  prmcu_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .d(rx_i), .q(w_rx));

  assign w_nbits = n_data_bits_i < 4'(MIN_DATA_BITS) ? 4'(MIN_DATA_BITS) :
                   n_data_bits_i > 4'(MAX_DATA_BITS) ? 4'(MAX_DATA_BITS) : n_data_bits_i;
  assign w_div = clk_divider_i < 8'(MIN_DIVIDER) ? 8'(MIN_DIVIDER) : clk_divider_i;
  assign w_start = rx_en & r_rx_prev & ~w_rx;
  // counter reloads with N and expires at 1, giving exactly N cycles per bit
  assign w_tick = r_cnt <= 8'd1;
  assign w_last_data = r_idx == r_nbits - 4'd1;
  assign w_last_stop = r_idx == {3'b000, r_stop2};
  assign w_done = rx_en & (r_state == STOP) & w_tick & w_last_stop;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_start ? START : IDLE;
      START:   w_next = w_tick ? (w_rx ? IDLE : DATA) : START;
      DATA:    w_next = (w_tick & w_last_data) ? (r_par ? PARITY : STOP) : DATA;
      PARITY:  w_next = w_tick ? STOP : PARITY;
      STOP:    w_next = (w_tick & w_last_stop) ? IDLE : STOP;
      default: w_next = IDLE;
    endcase
    if (!rx_en) w_next = IDLE;
  end

  always_ff @(posedge clk) r_state <= !rst ? IDLE : w_next;

  // configuration tracks the inputs while idle and freezes once a frame starts
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rx_prev <= 1'b1;
      r_cnt <= '0;
      r_idx <= '0;
      r_shift <= '0;
      r_xor <= 1'b0;
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
      r_nbits <= 4'(MIN_DATA_BITS);
      r_div <= 8'(MIN_DIVIDER);
      r_par <= 1'b0;
      r_stop2 <= 1'b0;
    end else begin
      r_rx_prev <= w_rx;
      if (r_state == IDLE) begin
        r_cnt <= {1'b0, w_div[7:1]};
        r_idx <= '0;
        r_shift <= '0;
        r_xor <= 1'b0;
        r_perr <= 1'b0;
        r_ferr <= 1'b0;
        r_nbits <= w_nbits;
        r_div <= w_div;
        r_par <= n_parity_bits_i;
        r_stop2 <= n_stop_bits_i[1];
      end else begin
        r_cnt <= w_tick ? r_div : r_cnt - 8'd1;
        if (w_tick) begin
          case (r_state)
            DATA: begin
              r_shift[r_idx] <= w_rx;
              r_xor <= r_xor ^ w_rx;
              r_idx <= w_last_data ? 4'd0 : r_idx + 4'd1;
            end
            PARITY: r_perr <= w_rx ^ r_xor;
            STOP: begin
              r_ferr <= r_ferr | ~w_rx;
              r_idx <= r_idx + 4'd1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // a completing frame loads only if the register is empty or draining this cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dat <= '0;
      r_vld <= 1'b0;
      r_pe <= 1'b0;
      r_fe <= 1'b0;
      r_ovr <= 1'b0;
    end else begin
      r_ovr <= w_done & r_vld & ~out_rdy_i;
      if (w_done & (~r_vld | out_rdy_i)) begin
        r_dat <= r_shift;
        r_pe <= r_perr;
        r_fe <= r_ferr | ~w_rx;
        r_vld <= 1'b1;
      end else if (out_rdy_i) r_vld <= 1'b0;
    end
  end

  assign out_dat_o = rst ? r_dat : '0;
  assign out_vld_o = rst & r_vld;
  assign parity_err_o = rst & r_pe;
  assign frame_err_o = rst & r_fe;
  assign overrun_err_o = rst & r_ovr;
  assign busy_o = rst & (r_state != IDLE);
endmodule
